// File: rtl/bcd_share_scheduler.sv
// Time-shares one binary-to-7-segment converter between three sensor channels and holds the last result for display.
// Optional macro SCHED_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority ch0 > ch1 > ch2.
module bcd_share_scheduler #(
    parameter int CONV_LATENCY = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [2:0] req_in,
    input  logic [7:0] data0_in,
    input  logic [7:0] data1_in,
    input  logic [7:0] data2_in,
    input  logic [6:0] seg_units_in,
    input  logic [6:0] seg_tens_in,
    input  logic [6:0] seg_hundreds_in,
    output logic [7:0] conv_bin_out,
    output logic [2:0] grant_out,
    output logic [2:0] ack_out,
    output logic       busy_out,
    output logic [6:0] disp_units_out,
    output logic [6:0] disp_tens_out,
    output logic [6:0] disp_hundreds_out,
    output logic [1:0] disp_ch_out,
    output logic       disp_valid_out
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_ACK} state_t;

    localparam logic [3:0] LAT = 4'(CONV_LATENCY);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] conv_q, conv_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] ack_q, ack_d;
    logic       busy_q, busy_d;
    logic [6:0] buf_u_q, buf_u_d, buf_t_q, buf_t_d, buf_h_q, buf_h_d;
    logic [6:0] disp_u_q, disp_u_d, disp_t_q, disp_t_d, disp_h_q, disp_h_d;
    logic [1:0] disp_ch_q, disp_ch_d;
    logic       disp_vld_q, disp_vld_d;

    logic [1:0] o0, o1, o2;
    logic [1:0] win_idx;
    logic [7:0] win_dat;
    logic [1:0] gnt_idx;

`ifdef SCHED_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search begins at the channel after the last one granted.
    always_comb begin
        case (ptr_q)
            2'd0:    {o0, o1, o2} = {2'd1, 2'd2, 2'd0};
            2'd1:    {o0, o1, o2} = {2'd2, 2'd0, 2'd1};
            default: {o0, o1, o2} = {2'd0, 2'd1, 2'd2};
        endcase
    end

    assign ptr_d = (state_q == S_IDLE && |req_in) ? win_idx : ptr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) ptr_q <= 2'd2;
        else        ptr_q <= ptr_d;
    end
`else
    assign o0 = 2'd0;
    assign o1 = 2'd1;
    assign o2 = 2'd2;
`endif

    always_comb begin
        if (req_in[o0])      win_idx = o0;
        else if (req_in[o1]) win_idx = o1;
        else                 win_idx = o2;
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_dat = data0_in;
            2'd1:    win_dat = data1_in;
            default: win_dat = data2_in;
        endcase
    end

    assign gnt_idx = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conv_d     = conv_q;
        grant_d    = grant_q;
        ack_d      = 3'b000;
        buf_u_d    = buf_u_q;
        buf_t_d    = buf_t_q;
        buf_h_d    = buf_h_q;
        disp_u_d   = disp_u_q;
        disp_t_d   = disp_t_q;
        disp_h_d   = disp_h_q;
        disp_ch_d  = disp_ch_q;
        disp_vld_d = disp_vld_q;
        case (state_q)
            S_IDLE: begin
                if (|req_in) begin
                    conv_d  = win_dat;
                    grant_d = 3'b001 << win_idx;
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                buf_u_d = seg_units_in;
                buf_t_d = seg_tens_in;
                buf_h_d = seg_hundreds_in;
                state_d = S_ACK;
            end
            default: begin
                // Whole display updates in one edge so it is never seen half-written.
                ack_d      = grant_q;
                disp_u_d   = buf_u_q;
                disp_t_d   = buf_t_q;
                disp_h_d   = buf_h_q;
                disp_ch_d  = gnt_idx;
                disp_vld_d = 1'b1;
                grant_d    = 3'b000;
                state_d    = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            conv_q     <= 8'd0;
            grant_q    <= 3'b000;
            ack_q      <= 3'b000;
            busy_q     <= 1'b0;
            buf_u_q    <= 7'd0;
            buf_t_q    <= 7'd0;
            buf_h_q    <= 7'd0;
            disp_u_q   <= 7'd0;
            disp_t_q   <= 7'd0;
            disp_h_q   <= 7'd0;
            disp_ch_q  <= 2'd0;
            disp_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conv_q     <= conv_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            buf_u_q    <= buf_u_d;
            buf_t_q    <= buf_t_d;
            buf_h_q    <= buf_h_d;
            disp_u_q   <= disp_u_d;
            disp_t_q   <= disp_t_d;
            disp_h_q   <= disp_h_d;
            disp_ch_q  <= disp_ch_d;
            disp_vld_q <= disp_vld_d;
        end
    end

    assign conv_bin_out      = conv_q;
    assign grant_out         = grant_q;
    assign ack_out           = ack_q;
    assign busy_out          = busy_q;
    assign disp_units_out    = disp_u_q;
    assign disp_tens_out     = disp_t_q;
    assign disp_hundreds_out = disp_h_q;
    assign disp_ch_out       = disp_ch_q;
    assign disp_valid_out    = disp_vld_q;
endmodule

// File: tb/tb_bcd_share_scheduler.sv
// Bench for bcd_share_scheduler: two instances (latency 2 and 5), each fed by a delay-line converter model.
module tb_bcd_share_scheduler;
    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][2:0] req;
    logic [7:0]      data0, data1, data2;
    logic [1:0][6:0] su, st, sh, du, dt, dh;
    logic [1:0][7:0] conv;
    logic [1:0][2:0] grant, ack;
    logic [1:0]      busy, dvld;
    logic [1:0][1:0] dch;
    logic [7:0]      dl0 [16];
    logic [7:0]      dl1 [16];

    int n_checks = 0;
    int n_fail   = 0;

    int         last [2];
    logic [6:0] eu [2];
    logic [6:0] et [2];
    logic [6:0] eh [2];
    int         ech [2];
    logic       evld [2];

    always #5 clk = ~clk;

    bcd_share_scheduler #(.CONV_LATENCY(2)) dut0 (
        .clk_in(clk), .rst_in(rst), .req_in(req[0]),
        .data0_in(data0), .data1_in(data1), .data2_in(data2),
        .seg_units_in(su[0]), .seg_tens_in(st[0]), .seg_hundreds_in(sh[0]),
        .conv_bin_out(conv[0]), .grant_out(grant[0]), .ack_out(ack[0]), .busy_out(busy[0]),
        .disp_units_out(du[0]), .disp_tens_out(dt[0]), .disp_hundreds_out(dh[0]),
        .disp_ch_out(dch[0]), .disp_valid_out(dvld[0]));

    bcd_share_scheduler #(.CONV_LATENCY(5)) dut1 (
        .clk_in(clk), .rst_in(rst), .req_in(req[1]),
        .data0_in(data0), .data1_in(data1), .data2_in(data2),
        .seg_units_in(su[1]), .seg_tens_in(st[1]), .seg_hundreds_in(sh[1]),
        .conv_bin_out(conv[1]), .grant_out(grant[1]), .ack_out(ack[1]), .busy_out(busy[1]),
        .disp_units_out(du[1]), .disp_tens_out(dt[1]), .disp_hundreds_out(dh[1]),
        .disp_ch_out(dch[1]), .disp_valid_out(dvld[1]));

    function automatic logic [6:0] seg7(input int dg);
        case (dg)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction
    function automatic logic [6:0] enc_u(input logic [7:0] v); return seg7(int'(v) % 10); endfunction
    function automatic logic [6:0] enc_t(input logic [7:0] v); return seg7((int'(v) / 10) % 10); endfunction
    function automatic logic [6:0] enc_h(input logic [7:0] v); return seg7(int'(v) / 100); endfunction

    // Converter: codes reflect conv_bin_out as it was LAT edges ago.
    always @(posedge clk) begin
        dl0[0] <= conv[0];
        dl1[0] <= conv[1];
        for (int k = 1; k < 16; k++) begin
            dl0[k] <= dl0[k-1];
            dl1[k] <= dl1[k-1];
        end
    end
    assign su[0] = enc_u(dl0[1]);
    assign st[0] = enc_t(dl0[1]);
    assign sh[0] = enc_h(dl0[1]);
    assign su[1] = enc_u(dl1[4]);
    assign st[1] = enc_t(dl1[4]);
    assign sh[1] = enc_h(dl1[4]);

    function automatic int model_pick(input logic [2:0] r, input int lastc);
`ifdef SCHED_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (lastc + k) % 3;
            if (r[c]) return c;
        end
`else
        for (int k = 0; k < 3; k++) if (r[k]) return k;
        if (lastc < 0) return 0;
`endif
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last[d] = 2; eu[d] = 0; et[d] = 0; eh[d] = 0; ech[d] = 0; evld[d] = 0;
        end
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk($sformatf("%s_d%0d_conv", tag, d), conv[d], 0);
        chk($sformatf("%s_d%0d_grant", tag, d), grant[d], 0);
        chk($sformatf("%s_d%0d_ack", tag, d), ack[d], 0);
        chk($sformatf("%s_d%0d_busy", tag, d), busy[d], 0);
        chk($sformatf("%s_d%0d_disp", tag, d), {du[d], dt[d], dh[d]}, 0);
        chk($sformatf("%s_d%0d_dch", tag, d), dch[d], 0);
        chk($sformatf("%s_d%0d_dvld", tag, d), dvld[d], 0);
    endtask

    task automatic grant_phase(input int d, input logic [2:0] r, input int ch, output logic [7:0] v);
        v = (ch == 0) ? data0 : (ch == 1) ? data1 : data2;
        req[d] = r;
        @(posedge clk); #1;
        last[d] = ch;
        chk($sformatf("d%0d_grant", d), grant[d], 3'b001 << ch);
        chk($sformatf("d%0d_conv_at_grant", d), conv[d], v);
        chk($sformatf("d%0d_busy_at_grant", d), busy[d], 1);
        chk($sformatf("d%0d_ack_at_grant", d), ack[d], 0);
    endtask

    task automatic ack_phase(input int d, input int ch, input logic [7:0] v, input bit hold);
        int  n   = 0;
        bit  got = 0;
        int  lat = (d == 0) ? 2 : 5;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[d] != 0) got = 1;
            else begin
                chk($sformatf("d%0d_grant_stable", d), grant[d], 3'b001 << ch);
                chk($sformatf("d%0d_conv_stable", d), conv[d], v);
                chk($sformatf("d%0d_busy_wait", d), busy[d], 1);
                chk($sformatf("d%0d_disp_held", d), {du[d], dt[d], dh[d], dch[d], dvld[d]},
                    {eu[d], et[d], eh[d], ech[d][1:0], evld[d]});
            end
        end
        chk($sformatf("d%0d_ack_seen", d), got, 1);
        chk($sformatf("d%0d_ack_latency", d), n, lat + 2);
        eu[d] = enc_u(v); et[d] = enc_t(v); eh[d] = enc_h(v); ech[d] = ch; evld[d] = 1;
        chk($sformatf("d%0d_ack_val", d), ack[d], 3'b001 << ch);
        chk($sformatf("d%0d_grant_cleared", d), grant[d], 0);
        chk($sformatf("d%0d_busy_at_ack", d), busy[d], 0);
        chk($sformatf("d%0d_disp_units", d), du[d], eu[d]);
        chk($sformatf("d%0d_disp_tens", d), dt[d], et[d]);
        chk($sformatf("d%0d_disp_hundreds", d), dh[d], eh[d]);
        chk($sformatf("d%0d_disp_ch", d), dch[d], ch);
        chk($sformatf("d%0d_disp_valid", d), dvld[d], 1);
        if (!hold) req[d] = 3'b000;
    endtask

    typedef struct {
        logic [2:0] r;
        logic [7:0] a, b, c;
        int         ch_fix;
        int         ch_rr;
    } vec_t;

    vec_t tbl [7];
    int   exp29 [4];

    initial begin
        logic [7:0] v;
        int         ch;

        tbl[0] = '{3'b001, 8'd123, 8'd11,  8'd22,  0, 0};
        tbl[1] = '{3'b110, 8'd1,   8'd45,  8'd9,   1, 1};
        tbl[2] = '{3'b101, 8'd0,   8'd60,  8'd255, 0, 2};
        tbl[3] = '{3'b011, 8'd77,  8'd200, 8'd3,   0, 0};
        tbl[4] = '{3'b100, 8'd8,   8'd8,   8'd0,   2, 2};
        tbl[5] = '{3'b111, 8'd10,  8'd20,  8'd30,  0, 0};
        tbl[6] = '{3'b010, 8'd5,   8'd255, 8'd6,   1, 1};
`ifdef SCHED_ROUND_ROBIN_EN
        exp29 = '{0, 1, 2, 0};
`else
        exp29 = '{0, 0, 0, 0};
`endif

        rst = 1'b1; req = '0; data0 = 0; data1 = 0; data2 = 0;
        model_reset();
        repeat (6) @(posedge clk);
        #1;
        chk_reset(0, "por");
        chk_reset(1, "por");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            data0 = tbl[i].a; data1 = tbl[i].b; data2 = tbl[i].c;
`ifdef SCHED_ROUND_ROBIN_EN
            ch = tbl[i].ch_rr;
`else
            ch = tbl[i].ch_fix;
`endif
            grant_phase(0, tbl[i].r, ch, v);
            ack_phase(0, ch, v, 0);
        end

        // Data and request change while the conversion is in flight.
        data1 = 8'd45;
        ch = model_pick(3'b010, last[0]);
        grant_phase(0, 3'b010, ch, v);
        data1 = 8'd200;
        req[0] = 3'b000;
        ack_phase(0, ch, v, 0);
        chk("inflight_units_45", du[0], enc_u(8'd45));

        // Reset in the middle of WAIT aborts without ack.
        data2 = 8'd99;
        ch = model_pick(3'b100, last[0]);
        grant_phase(0, 3'b100, ch, v);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        req[0] = 3'b000;
        model_reset();
        chk_reset(0, "midrst");
        chk_reset(1, "midrst");
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_ack", ack[0], 0);
        end

        // All three requesting continuously, starting right after reset.
        data0 = 8'd31; data1 = 8'd132; data2 = 8'd250;
        for (int k = 0; k < 4; k++) begin
            grant_phase(0, 3'b111, exp29[k], v);
            ack_phase(0, exp29[k], v, 1);
        end
        req[0] = 3'b000;

        // Latency-5 instance: capture must pick up the new value, not the stale one.
        data0 = 8'd87; data2 = 8'd255;
        ch = model_pick(3'b001, last[1]);
        grant_phase(1, 3'b001, ch, v);
        req[1] = 3'b000;
        ack_phase(1, ch, v, 0);
        ch = model_pick(3'b100, last[1]);
        grant_phase(1, 3'b100, ch, v);
        ack_phase(1, ch, v, 0);

        for (int i = 0; i < 36; i++) begin
            logic [2:0] r;
            int         d;
            d = (i % 4 == 3) ? 1 : 0;
            r = 3'($urandom_range(1, 7));
            data0 = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
            ch = model_pick(r, last[d]);
            grant_phase(d, r, ch, v);
            if ($urandom_range(0, 1) == 1) begin
                req[d] = 3'b000;
                data0 = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
            end
            ack_phase(d, ch, v, 0);
        end

        @(posedge clk); #1;
        chk("final_idle_d0", busy[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
